// File: rtl/d8_fetch.sv
// ---------------------------------------------------------------------------
// d8_fetch : instruction fetch sequencer for the d8 core.
//
// Owns the PC and issues at most one read per cycle to the instruction
// memory (1-cycle read latency). Returned words go into a 2-entry FIFO of
// {pc, word}; the head of that FIFO is presented to decode with a
// valid/ready handshake. A branch redirect squashes the in-flight read and
// every buffered word except the one handed over in the redirect cycle.
//
// Optional feature macro: D8_FETCH_PERF_EN
//   When defined, adds perf_fetch[15:0], a wrapping count of completed
//   transfers (ins_valid & ins_ready).
//
// Ports
//   sys_clk    in   1   system clock, all state on posedge
//   sys_rst    in   1   synchronous reset, active-low
//   mem_en     out  1   read strobe to instruction memory (combinational)
//   mem_adr    out  8   read byte address (combinational)
//   mem_dout   in   32  read data, valid the cycle after mem_en=1
//   ins        out  32  instruction word to decode (registered)
//   ins_pc     out  8   address ins was fetched from (registered)
//   ins_valid  out  1   ins/ins_pc valid (registered)
//   ins_ready  in   1   decode accepts
//   br_en      in   1   redirect request, single-cycle pulse
//   br_adr     in   8   redirect target
//   halt       in   1   1 = issue no new fetches
//   perf_fetch out  16  transfer counter (only with D8_FETCH_PERF_EN)
// ---------------------------------------------------------------------------
module d8_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        mem_en,
    output logic [7:0]  mem_adr,
    input  logic [31:0] mem_dout,
    output logic [31:0] ins,
    output logic [7:0]  ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        br_en,
    input  logic [7:0]  br_adr,
    input  logic        halt
`ifdef D8_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch
`endif
);

    logic [7:0]  pc_r;
    logic        inflight_r;
    logic [7:0]  inflight_adr_r;
    logic [7:0]  head_pc_r;
    logic [31:0] head_word_r;
    logic [7:0]  tail_pc_r;
    logic [31:0] tail_word_r;
    logic [1:0]  cnt_r;
    logic        valid_r;

    logic        deq_s;
    logic        push_s;
    logic [2:0]  occ_s;
    logic        issue_ok_s;
    logic [1:0]  cnt_pop_s;
    logic [1:0]  cnt_n_s;
    logic [7:0]  head_pc_n_s;
    logic [31:0] head_word_n_s;
    logic [7:0]  tail_pc_n_s;
    logic [31:0] tail_word_n_s;

    assign deq_s = valid_r & ins_ready;

    // A returning read is written unless a redirect in this cycle squashes it.
    assign push_s = inflight_r & ~br_en;

    // Occupancy the FIFO would reach if nothing new is issued now.
    assign occ_s = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, deq_s};

    // A redirect flushes the FIFO and squashes the in-flight read, so it
    // always leaves room for the target fetch.
    assign issue_ok_s = br_en | (occ_s < 3'd2);

    // Read request: forced off during reset and while halted.
    always_comb begin
        mem_adr = pc_r;
        mem_en  = 1'b0;
        if (br_en) begin
            mem_adr = br_adr;
        end else begin
            mem_adr = pc_r;
        end
        if (sys_rst && !halt && issue_ok_s) begin
            mem_en = 1'b1;
        end else begin
            mem_en = 1'b0;
        end
    end

    // FIFO next-state: pop head on transfer, then append the returned word.
    always_comb begin
        head_pc_n_s   = head_pc_r;
        head_word_n_s = head_word_r;
        tail_pc_n_s   = tail_pc_r;
        tail_word_n_s = tail_word_r;
        cnt_pop_s     = cnt_r - {1'b0, deq_s};
        cnt_n_s       = cnt_r;
        if (deq_s) begin
            head_pc_n_s   = tail_pc_r;
            head_word_n_s = tail_word_r;
        end else begin
            head_pc_n_s   = head_pc_r;
            head_word_n_s = head_word_r;
        end
        if (push_s) begin
            if (cnt_pop_s == 2'd0) begin
                head_pc_n_s   = inflight_adr_r;
                head_word_n_s = mem_dout;
            end else begin
                tail_pc_n_s   = inflight_adr_r;
                tail_word_n_s = mem_dout;
            end
        end else begin
            tail_pc_n_s   = tail_pc_r;
            tail_word_n_s = tail_word_r;
        end
        if (br_en) begin
            cnt_n_s = 2'd0;
        end else begin
            cnt_n_s = cnt_pop_s + {1'b0, push_s};
        end
    end

    // PC, in-flight tracking and FIFO storage.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            pc_r           <= RESET_PC;
            inflight_r     <= 1'b0;
            inflight_adr_r <= 8'h00;
            head_pc_r      <= 8'h00;
            head_word_r    <= 32'h0000_0000;
            tail_pc_r      <= 8'h00;
            tail_word_r    <= 32'h0000_0000;
            cnt_r          <= 2'd0;
            valid_r        <= 1'b0;
        end else begin
            if (mem_en) begin
                pc_r <= mem_adr + 8'h04;
            end else if (br_en) begin
                // Redirect while halted: remember the target, fetch later.
                pc_r <= br_adr;
            end else begin
                pc_r <= pc_r;
            end
            inflight_r     <= mem_en;
            inflight_adr_r <= mem_adr;
            head_pc_r      <= head_pc_n_s;
            head_word_r    <= head_word_n_s;
            tail_pc_r      <= tail_pc_n_s;
            tail_word_r    <= tail_word_n_s;
            cnt_r          <= cnt_n_s;
            valid_r        <= (cnt_n_s != 2'd0);
        end
    end

    assign ins       = head_word_r;
    assign ins_pc    = head_pc_r;
    assign ins_valid = valid_r;

`ifdef D8_FETCH_PERF_EN
    logic [15:0] perf_r;

    // Transfer counter; squashed words never handshake so are never counted.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            perf_r <= 16'h0000;
        end else if (deq_s) begin
            perf_r <= perf_r + 16'h0001;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_fetch = perf_r;
`endif

endmodule

// File: tb/tb_d8_fetch.sv
// Directed self-checking bench for d8_fetch.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_d8_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        mem_en;
    logic [7:0]  mem_adr;
    logic [31:0] mem_dout;
    logic [31:0] ins;
    logic [7:0]  ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        br_en;
    logic [7:0]  br_adr;
    logic        halt;
`ifdef D8_FETCH_PERF_EN
    logic [15:0] perf_fetch;
`endif

    int total = 0;
    int bad   = 0;

    d8_fetch #(.RESET_PC(8'h00)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mem_en    (mem_en),
        .mem_adr   (mem_adr),
        .mem_dout  (mem_dout),
        .ins       (ins),
        .ins_pc    (ins_pc),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .br_en     (br_en),
        .br_adr    (br_adr),
        .halt      (halt)
`ifdef D8_FETCH_PERF_EN
        ,
        .perf_fetch(perf_fetch)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Instruction memory model: word content encodes its own address.
    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {8'h09, a, 16'h0000};
    endfunction

    always @(posedge sys_clk) begin
        if (mem_en) mem_dout <= word_of(mem_adr);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Apply reset for two cycles and release it; caller is then in cycle 0.
    task automatic do_reset();
        sys_rst = 1'b0; halt = 1'b0; br_en = 1'b0; br_adr = 8'h00; ins_ready = 1'b1;
        tick();
        tick();
        sys_rst = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; halt = 1'b0; br_en = 1'b0; br_adr = 8'h00; ins_ready = 1'b1;
        tick();
        tick();
        @(negedge sys_clk);
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ins_valid); end
        total++; if (ins !== 32'h0) begin bad++; $display("FAIL rst_ins got=%h exp=0", ins); end
        total++; if (ins_pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", ins_pc); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
`ifdef D8_FETCH_PERF_EN
        total++; if (perf_fetch !== 16'h0) begin bad++; $display("FAIL rst_perf got=%0d exp=0", perf_fetch); end
`endif
        tick();
    endtask

    task automatic test_stream();
        logic [7:0] e;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (c < 8) begin
                e = 8'(4 * c);
                total++; if (mem_en !== 1'b1 || mem_adr !== e) begin bad++; $display("FAIL stream_issue c=%0d got=%b/%h exp=1/%h", c, mem_en, mem_adr, e); end
            end
            total++; if (ins_valid !== (c >= 2)) begin bad++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, ins_valid, (c >= 2)); end
            if (c >= 2) begin
                e = 8'(4 * (c - 2));
                total++; if (ins_pc !== e || ins !== word_of(e)) begin bad++; $display("FAIL stream_word c=%0d got=%h/%h exp=%h/%h", c, ins_pc, ins, e, word_of(e)); end
            end
            tick();
        end
        ins_ready = 1'b0;
        @(negedge sys_clk);
`ifdef D8_FETCH_PERF_EN
        total++; if (perf_fetch !== 16'd8) begin bad++; $display("FAIL stream_perf got=%0d exp=8", perf_fetch); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_pc;
        int issues;
        int xfers;
        exp_pc = 8'h00; issues = 0; xfers = 0;
        do_reset();
        for (int c = 0; c < 19; c++) begin
            ins_ready = (c >= 6 && c <= 10) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            if (c >= 6 && c <= 10) begin
                if (mem_en) issues++;
                total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h10 || ins !== word_of(8'h10)) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/10/%h", c, ins_valid, ins_pc, ins, word_of(8'h10)); end
            end
            if (c >= 11) begin
                total++; if (ins_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid c=%0d got=%b exp=1", c, ins_valid); end
            end
            if (ins_valid && ins_ready) begin
                total++; if (ins_pc !== exp_pc || ins !== word_of(exp_pc)) begin bad++; $display("FAIL bp_order c=%0d got=%h/%h exp=%h/%h", c, ins_pc, ins, exp_pc, word_of(exp_pc)); end
                exp_pc = exp_pc + 8'h04;
                xfers++;
            end
            tick();
        end
        total++; if (issues > 2) begin bad++; $display("FAIL bp_issues got=%0d exp<=2", issues); end
        total++; if (xfers != 12) begin bad++; $display("FAIL bp_xfers got=%0d exp=12", xfers); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            ins_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            br_en  = (c == 5 || c == 9) ? 1'b1 : 1'b0;
            br_adr = (c == 5) ? 8'h1C : ((c == 9) ? 8'h40 : 8'h00);
            @(negedge sys_clk);
            case (c)
                5: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h08) begin bad++; $display("FAIL br_full_head got=%b/%h exp=1/08", ins_valid, ins_pc); end
                    total++; if (mem_en !== 1'b1 || mem_adr !== 8'h1C) begin bad++; $display("FAIL br_full_issue got=%b/%h exp=1/1c", mem_en, mem_adr); end
                end
                6: begin
                    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL br_full_bubble got=%b exp=0", ins_valid); end
                end
                7: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h1C || ins !== 32'h091C0000) begin bad++; $display("FAIL br_target got=%b/%h/%h exp=1/1c/091c0000", ins_valid, ins_pc, ins); end
                end
                8: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h20) begin bad++; $display("FAIL br_next got=%b/%h exp=1/20", ins_valid, ins_pc); end
                end
                9: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h24 || mem_en !== 1'b1 || mem_adr !== 8'h40) begin bad++; $display("FAIL br_inflight got=%b/%h/%b/%h exp=1/24/1/40", ins_valid, ins_pc, mem_en, mem_adr); end
                end
                10: begin
                    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL br_squash got=%b exp=0", ins_valid); end
                end
                11: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h40) begin bad++; $display("FAIL br2_target got=%b/%h exp=1/40", ins_valid, ins_pc); end
                end
                12: begin
                    total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h44) begin bad++; $display("FAIL br2_next got=%b/%h exp=1/44", ins_valid, ins_pc); end
`ifdef D8_FETCH_PERF_EN
                    total++; if (perf_fetch !== 16'd6) begin bad++; $display("FAIL br_perf got=%0d exp=6", perf_fetch); end
`endif
                end
                default: begin end
            endcase
            tick();
        end
        br_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            br_en  = (c == 0) ? 1'b1 : 1'b0;
            br_adr = 8'hF8;
            @(negedge sys_clk);
            if (c == 0) begin total++; if (mem_adr !== 8'hF8 || mem_en !== 1'b1) begin bad++; $display("FAIL wrap_f8 got=%b/%h exp=1/f8", mem_en, mem_adr); end end
            if (c == 1) begin total++; if (mem_adr !== 8'hFC || mem_en !== 1'b1) begin bad++; $display("FAIL wrap_fc got=%b/%h exp=1/fc", mem_en, mem_adr); end end
            if (c == 2) begin
                total++; if (mem_adr !== 8'h00 || mem_en !== 1'b1) begin bad++; $display("FAIL wrap_00 got=%b/%h exp=1/00", mem_en, mem_adr); end
                total++; if (ins_pc !== 8'hF8 || ins !== 32'h09F80000) begin bad++; $display("FAIL wrap_ins_f8 got=%h/%h exp=f8/09f80000", ins_pc, ins); end
            end
            if (c == 3) begin total++; if (ins_pc !== 8'hFC) begin bad++; $display("FAIL wrap_ins_fc got=%h exp=fc", ins_pc); end end
            if (c == 4) begin total++; if (ins_pc !== 8'h00 || ins !== 32'h09000000 || ins_valid !== 1'b1) begin bad++; $display("FAIL wrap_ins_00 got=%b/%h/%h exp=1/00/09000000", ins_valid, ins_pc, ins); end end
            tick();
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            halt   = (c >= 4 && c <= 8) ? 1'b1 : 1'b0;
            br_en  = (c == 7) ? 1'b1 : 1'b0;
            br_adr = 8'h80;
            @(negedge sys_clk);
            if (c >= 4 && c <= 8) begin
                total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL halt_no_issue c=%0d got=%b exp=0", c, mem_en); end
            end
            if (c == 4) begin total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h08) begin bad++; $display("FAIL halt_drain0 got=%b/%h exp=1/08", ins_valid, ins_pc); end end
            if (c == 5) begin total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h0C) begin bad++; $display("FAIL halt_drain1 got=%b/%h exp=1/0c", ins_valid, ins_pc); end end
            if (c == 6 || c == 8 || c == 10) begin total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL halt_empty c=%0d got=%b exp=0", c, ins_valid); end end
            if (c == 9) begin total++; if (mem_en !== 1'b1 || mem_adr !== 8'h80) begin bad++; $display("FAIL halt_resume got=%b/%h exp=1/80", mem_en, mem_adr); end end
            if (c == 10) begin total++; if (mem_en !== 1'b1 || mem_adr !== 8'h84) begin bad++; $display("FAIL halt_resume2 got=%b/%h exp=1/84", mem_en, mem_adr); end end
            if (c == 11) begin total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h80 || ins !== 32'h09800000) begin bad++; $display("FAIL halt_first got=%b/%h/%h exp=1/80/09800000", ins_valid, ins_pc, ins); end end
            tick();
        end
        halt = 1'b0; br_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            sys_rst = (c == 5 || c == 6) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            if (c == 4) begin total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h08) begin bad++; $display("FAIL mrst_pre got=%b/%h exp=1/08", ins_valid, ins_pc); end end
            if (c == 5) begin total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL mrst_mem_en got=%b exp=0", mem_en); end end
            if (c == 6) begin
                total++; if (ins_valid !== 1'b0 || mem_en !== 1'b0 || ins_pc !== 8'h00 || ins !== 32'h0) begin bad++; $display("FAIL mrst_cleared got=%b/%b/%h/%h exp=0/0/00/0", ins_valid, mem_en, ins_pc, ins); end
`ifdef D8_FETCH_PERF_EN
                total++; if (perf_fetch !== 16'h0) begin bad++; $display("FAIL mrst_perf got=%0d exp=0", perf_fetch); end
`endif
            end
            if (c == 7) begin total++; if (mem_en !== 1'b1 || mem_adr !== 8'h00) begin bad++; $display("FAIL mrst_restart got=%b/%h exp=1/00", mem_en, mem_adr); end end
            if (c == 8) begin total++; if (ins_valid !== 1'b0 || mem_adr !== 8'h04) begin bad++; $display("FAIL mrst_no_stale got=%b/%h exp=0/04", ins_valid, mem_adr); end end
            if (c == 9) begin total++; if (ins_valid !== 1'b1 || ins_pc !== 8'h00 || ins !== 32'h09000000) begin bad++; $display("FAIL mrst_first got=%b/%h/%h exp=1/00/09000000", ins_valid, ins_pc, ins); end end
            tick();
        end
    endtask

    initial begin
        sys_rst = 1'b0; halt = 1'b0; br_en = 1'b0; br_adr = 8'h00; ins_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
